net_interface_unit: RTL and testbench
=====================================

# net_interface_unit

Core-side network interface for the neuromorphic accelerator CPU core. It sits after the EX/MEM pipeline register and services the MEM-stage network write and network read requests. Outgoing packets (destination address plus payload) are buffered in a TX FIFO toward the NoC router. Incoming router packets are buffered in an RX FIFO and popped by network reads. Handshakes on both router ports are valid/ready, and the block raises a pipeline stall when a request cannot complete.

## Interface
Parameters:
- TX_DEPTH, 4 — TX FIFO entries; power of two, ≥2.
- RX_DEPTH, 4 — RX FIFO entries; power of two, ≥2.

Ports:
- CLK  in  1  — single clock; all state updates on posedge.
- RESET  in  1  — synchronous, active-low; RESET==0 at a posedge resets the block.
- MEM_NET_WRITE  in  1  — MEM-stage network write request.
- MEM_NET_READ  in  1  — MEM-stage network read request.
- MEM_ALU_OUT  in  32  — destination address for a write.
- MEM_REG_DATA2  in  32  — payload for a write.
- NET_READ_DATA  out  32  — read result; RX head, else 0.
- NET_STALL  out  1  — combinational; high when a request cannot be accepted this cycle.
- TX_VALID  out  1 ; TX_ADDR  out  32 ; TX_DATA  out  32 — TX head toward router.
- TX_READY  in  1 — router accepts TX head.
- RX_VALID  in  1 ; RX_DATA  in  32 — packet from router.
- RX_READY  out  1 — RX FIFO can accept.

## Operation
- Each FIFO has read/write pointers (log2 DEPTH bits, wrapping modulo DEPTH) and an occupancy count (log2 DEPTH + 1 bits).
- TX push: MEM_NET_WRITE && tx_count<TX_DEPTH. Stores {MEM_ALU_OUT, MEM_REG_DATA2}.
- TX pop: TX_VALID && TX_READY.
- Full-FIFO rule: when full, a push is refused even if a pop occurs in the same cycle. The write stalls one more cycle.
- Non-full push with simultaneous pop: count unchanged, both pointers advance.
- RX push: RX_VALID && RX_READY, where RX_READY = (rx_count<RX_DEPTH).
- RX pop: MEM_NET_READ && rx_count!=0. NET_READ_DATA is the RX head during that cycle.
- NET_STALL = (MEM_NET_WRITE && tx full) || (MEM_NET_READ && rx empty, subject to bypass below).
- While stalled, the pipeline holds the request stable. The block takes no state action for the stalled request.
- Write and read in the same cycle are independent. NET_STALL is the OR of both conditions. The non-stalled side still commits, and the pipeline must not re-issue it.
- TX_VALID = tx_count!=0. TX_ADDR/TX_DATA show the head, and show 0 when empty.
- Router contract: TX_ADDR/TX_DATA are stable while TX_VALID && !TX_READY.
- NET_READ_DATA = RX head when rx_count!=0, else 0.
- Reset (RESET==0 at posedge): pointers and counts go to 0, giving TX_VALID=0, TX_ADDR=TX_DATA=0, NET_READ_DATA=0, RX_READY=1 after the edge, and NET_STALL driven only by the current requests.
- Reset mid-operation discards all buffered packets. An RX handshake on the reset edge is dropped.

## Timing
- TX: push at edge N makes TX_VALID high after edge N (one-cycle latency into an empty FIFO).
- RX: handshake at edge N makes the data readable on NET_READ_DATA after edge N.
- Pop and push take effect at the same edge. The next head appears after that edge.
- Throughput is one push and one pop per FIFO per cycle.
- NET_STALL, RX_READY and TX_VALID are functions of the registered count and the current inputs only. There is no combinational path from TX_READY to TX_VALID.

## Configuration
- NET_RX_BYPASS_EN defined: when the RX FIFO is empty, MEM_NET_READ=1 and RX_VALID=1, then NET_READ_DATA=RX_DATA in the same cycle. NET_STALL is not raised for the read. RX_READY=1 and the packet is consumed without entering the FIFO (count stays 0).
- Bypass applies only when the FIFO is empty. When it is non-empty, normal FIFO order is preserved.
- NET_RX_BYPASS_EN undefined: an empty-FIFO read always stalls. The arriving packet is pushed and becomes readable the next cycle.

## Test plan
- Reset: hold RESET=0 for 2 cycles with random inputs -> TX_VALID=0, NET_READ_DATA=0, counts 0; after release, RX_READY=1.
- TX fill: 5 consecutive writes (addr 0x10+i, data 0xA0+i) with TX_READY=0 and TX_DEPTH=4 -> 4 accepted, NET_STALL=1 on the 5th. Then TX_READY=1 -> packets emitted in order 0x10..0x13, then the 5th write accepted.
- Full with simultaneous pop: TX full, TX_READY=1 and a write in the same cycle -> the write stalls that cycle and is accepted the next; count goes 4→3→4.
- RX backpressure: push 4 packets 0x100..0x103 -> RX_READY=0. A 5th RX_VALID is held by the router. Reads return 0x100..0x103 in order, and RX_READY rises after the first pop.
- Empty read: MEM_NET_READ with empty RX and RX_VALID=1, RX_DATA=0xDEAD -> without the macro: NET_STALL=1, then 0xDEAD read next cycle; with NET_RX_BYPASS_EN: NET_STALL=0, NET_READ_DATA=0xDEAD same cycle, count stays 0.
- Concurrent: a write into a full TX together with a read from a non-empty RX -> NET_STALL=1, the read pops once, and the write completes later.

Source files
------------

// File: rtl/net_interface_unit.sv
// Core-side NoC interface: TX FIFO toward router, RX FIFO from router, MEM-stage stall.
// Latency: one cycle push-to-visible on both FIFOs; optional zero-cycle RX bypass when empty.
// Backpressure: NET_STALL when TX full / RX empty, RX_READY low when RX full. Macro: NET_RX_BYPASS_EN.
module net_interface_unit #(
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MEM_NET_WRITE,
  input  logic        MEM_NET_READ,
  input  logic [31:0] MEM_ALU_OUT,
  input  logic [31:0] MEM_REG_DATA2,
  output logic [31:0] NET_READ_DATA,
  output logic        NET_STALL,
  output logic        TX_VALID,
  output logic [31:0] TX_ADDR,
  output logic [31:0] TX_DATA,
  input  logic        TX_READY,
  input  logic        RX_VALID,
  input  logic [31:0] RX_DATA,
  output logic        RX_READY
);

  localparam int TPW = $clog2(TX_DEPTH);
  localparam int TCW = TPW + 1;
  localparam int RPW = $clog2(RX_DEPTH);
  localparam int RCW = RPW + 1;
  localparam logic [TCW-1:0] TX_FULL_CNT = TCW'(TX_DEPTH);
  localparam logic [RCW-1:0] RX_FULL_CNT = RCW'(RX_DEPTH);

  // TX entries hold {destination address, payload}
  logic [63:0]    r_tx_mem [TX_DEPTH];
  logic [TPW-1:0] r_tx_wptr;
  logic [TPW-1:0] r_tx_rptr;
  logic [TCW-1:0] r_tx_count;

  logic [31:0]    r_rx_mem [RX_DEPTH];
  logic [RPW-1:0] r_rx_wptr;
  logic [RPW-1:0] r_rx_rptr;
  logic [RCW-1:0] r_rx_count;

  logic        w_tx_full;
  logic        w_tx_empty;
  logic        w_tx_push;
  logic        w_tx_pop;
  logic [63:0] w_tx_head;
  logic        w_rx_full;
  logic        w_rx_empty;
  logic        w_rx_push;
  logic        w_rx_pop;
  logic        w_rx_bypass;
  logic [31:0] w_rx_head;

  assign w_tx_full  = (r_tx_count == TX_FULL_CNT);
  assign w_tx_empty = (r_tx_count == '0);
  assign w_rx_full  = (r_rx_count == RX_FULL_CNT);
  assign w_rx_empty = (r_rx_count == '0);

  // A full FIFO refuses a push even when the head leaves in the same cycle,
  // so push qualification looks only at the registered count.
  assign w_tx_push = MEM_NET_WRITE && !w_tx_full;
  assign w_tx_pop  = !w_tx_empty && TX_READY;

`ifdef NET_RX_BYPASS_EN
  // Empty FIFO plus a waiting read: hand the router packet straight to the core.
  assign w_rx_bypass = MEM_NET_READ && RX_VALID && w_rx_empty;
`else
  assign w_rx_bypass = 1'b0;
`endif

  assign RX_READY  = !w_rx_full;
  assign w_rx_push = RX_VALID && RX_READY && !w_rx_bypass;
  assign w_rx_pop  = MEM_NET_READ && !w_rx_empty;

  assign w_tx_head = r_tx_mem[r_tx_rptr];
  assign w_rx_head = r_rx_mem[r_rx_rptr];

  // Head is masked to zero when empty so stale storage never leaks out.
  assign TX_VALID = !w_tx_empty;
  assign TX_ADDR  = w_tx_empty ? 32'h0 : w_tx_head[63:32];
  assign TX_DATA  = w_tx_empty ? 32'h0 : w_tx_head[31:0];

  assign NET_READ_DATA = !w_rx_empty ? w_rx_head :
                         (w_rx_bypass ? RX_DATA : 32'h0);

  // Either side may stall; the other side still commits this cycle.
  assign NET_STALL = (MEM_NET_WRITE && w_tx_full) ||
                     (MEM_NET_READ && w_rx_empty && !w_rx_bypass);

  // Storage writes need no reset: pointers and counts gate all reads.
  always_ff @(posedge CLK) begin
    if (w_tx_push) r_tx_mem[r_tx_wptr] <= {MEM_ALU_OUT, MEM_REG_DATA2};
    if (w_rx_push) r_rx_mem[r_rx_wptr] <= RX_DATA;
  end

  // TX pointers and occupancy; pointers wrap naturally at power-of-two depth.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_tx_wptr  <= '0;
      r_tx_rptr  <= '0;
      r_tx_count <= '0;
    end else begin
      if (w_tx_push) r_tx_wptr <= r_tx_wptr + TPW'(1);
      if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + TPW'(1);
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_count <= r_tx_count + TCW'(1);
        2'b01:   r_tx_count <= r_tx_count - TCW'(1);
        default: r_tx_count <= r_tx_count;
      endcase
    end
  end

  // RX pointers and occupancy; a handshake on the reset edge is discarded.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_rx_wptr  <= '0;
      r_rx_rptr  <= '0;
      r_rx_count <= '0;
    end else begin
      if (w_rx_push) r_rx_wptr <= r_rx_wptr + RPW'(1);
      if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + RPW'(1);
      case ({w_rx_push, w_rx_pop})
        2'b10:   r_rx_count <= r_rx_count + RCW'(1);
        2'b01:   r_rx_count <= r_rx_count - RCW'(1);
        default: r_rx_count <= r_rx_count;
      endcase
    end
  end

endmodule

// File: tb/tb_net_interface_unit.sv
// Scoreboard bench for net_interface_unit: queue model of both FIFOs checked every cycle.
// Inputs driven 1 time unit after posedge; outputs sampled on negedge.
// Directed scenarios (reset, TX fill, full+pop, RX backpressure, empty read, concurrent) then random traffic.
module tb_net_interface_unit;

  localparam int TXD = 4;
  localparam int RXD = 4;
`ifdef NET_RX_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RESET;
  logic        MEM_NET_WRITE;
  logic        MEM_NET_READ;
  logic [31:0] MEM_ALU_OUT;
  logic [31:0] MEM_REG_DATA2;
  logic [31:0] NET_READ_DATA;
  logic        NET_STALL;
  logic        TX_VALID;
  logic [31:0] TX_ADDR;
  logic [31:0] TX_DATA;
  logic        TX_READY;
  logic        RX_VALID;
  logic [31:0] RX_DATA;
  logic        RX_READY;

  net_interface_unit #(.TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
    .CLK(CLK), .RESET(RESET),
    .MEM_NET_WRITE(MEM_NET_WRITE), .MEM_NET_READ(MEM_NET_READ),
    .MEM_ALU_OUT(MEM_ALU_OUT), .MEM_REG_DATA2(MEM_REG_DATA2),
    .NET_READ_DATA(NET_READ_DATA), .NET_STALL(NET_STALL),
    .TX_VALID(TX_VALID), .TX_ADDR(TX_ADDR), .TX_DATA(TX_DATA), .TX_READY(TX_READY),
    .RX_VALID(RX_VALID), .RX_DATA(RX_DATA), .RX_READY(RX_READY)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;
  bit armed = 1'b0;
  logic [63:0] tx_q[$];
  logic [31:0] rx_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Compare outputs against the queue model, then advance the model to match the coming edge.
  always @(negedge CLK) begin
    int  txn;
    int  rxn;
    bit  byp;
    logic [31:0] exp_rd;
    txn = tx_q.size();
    rxn = rx_q.size();
    byp = BYP && MEM_NET_READ && RX_VALID && (rxn == 0);
    exp_rd = (rxn != 0) ? rx_q[0] : (byp ? RX_DATA : 32'h0);
    if (armed) begin
      check("tx_valid", 32'(TX_VALID), 32'(txn != 0));
      check("tx_addr",  TX_ADDR, (txn != 0) ? tx_q[0][63:32] : 32'h0);
      check("tx_data",  TX_DATA, (txn != 0) ? tx_q[0][31:0]  : 32'h0);
      check("rx_ready", 32'(RX_READY), 32'(rxn < RXD));
      check("stall",    32'(NET_STALL),
            32'((MEM_NET_WRITE && txn == TXD) || (MEM_NET_READ && rxn == 0 && !byp)));
      check("rd_data",  NET_READ_DATA, exp_rd);
    end
    if (!RESET) begin
      tx_q.delete();
      rx_q.delete();
      armed = 1'b1;
    end else begin
      if (txn != 0 && TX_READY) void'(tx_q.pop_front());
      if (MEM_NET_WRITE && txn < TXD) tx_q.push_back({MEM_ALU_OUT, MEM_REG_DATA2});
      if (MEM_NET_READ && rxn != 0) void'(rx_q.pop_front());
      if (RX_VALID && rxn < RXD && !byp) rx_q.push_back(RX_DATA);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    MEM_NET_WRITE = 1'b0;
    MEM_NET_READ  = 1'b0;
    MEM_ALU_OUT   = 32'h0;
    MEM_REG_DATA2 = 32'h0;
    RX_VALID      = 1'b0;
    RX_DATA       = 32'h0;
  endtask

  // Hold a write until it is no longer stalled, bounded.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    bit st;
    int n;
    MEM_NET_WRITE = 1'b1;
    MEM_ALU_OUT   = a;
    MEM_REG_DATA2 = d;
    n = 0;
    do begin
      @(negedge CLK);
      st = NET_STALL;
      tick();
      n++;
    end while (st && n < 20);
    MEM_NET_WRITE = 1'b0;
    check("write_done", 32'(st), 32'h0);
  endtask

  // Hold an RX packet until the FIFO takes it, bounded.
  task automatic rx_send(input logic [31:0] d);
    bit rdy;
    int n;
    RX_VALID = 1'b1;
    RX_DATA  = d;
    n = 0;
    do begin
      @(negedge CLK);
      rdy = RX_READY;
      tick();
      n++;
    end while (!rdy && n < 20);
    RX_VALID = 1'b0;
    check("rx_accepted", 32'(rdy), 32'h1);
  endtask

  initial begin
    bit rdy;
    bit st;
    int n;

    // Reset held two cycles with random inputs
    RESET = 1'b0;
    TX_READY = 1'($urandom_range(0, 1));
    MEM_NET_WRITE = 1'($urandom_range(0, 1));
    MEM_NET_READ  = 1'($urandom_range(0, 1));
    MEM_ALU_OUT   = $urandom();
    MEM_REG_DATA2 = $urandom();
    RX_VALID      = 1'($urandom_range(0, 1));
    RX_DATA       = $urandom();
    tick();
    tick();
    RESET = 1'b1;
    idle_inputs();
    TX_READY = 1'b0;
    tick();

    // TX fill: four accepted, fifth stalls until router drains
    for (int i = 0; i < 4; i++) do_write(32'h10 + i, 32'hA0 + i);
    MEM_NET_WRITE = 1'b1;
    MEM_ALU_OUT   = 32'h14;
    MEM_REG_DATA2 = 32'hA4;
    tick();
    tick();
    // Full with pop in the same cycle: write still refused that cycle
    TX_READY = 1'b1;
    n = 0;
    do begin
      @(negedge CLK);
      st = NET_STALL;
      tick();
      n++;
    end while (st && n < 20);
    MEM_NET_WRITE = 1'b0;
    check("fifth_write", 32'(st), 32'h0);
    repeat (6) tick();

    // RX backpressure: fill, hold a fifth, then read everything back in order
    for (int i = 0; i < 4; i++) rx_send(32'h100 + i);
    RX_VALID = 1'b1;
    RX_DATA  = 32'h104;
    tick();
    tick();
    MEM_NET_READ = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      rdy = RX_READY;
      tick();
      if (rdy) RX_VALID = 1'b0;
    end
    MEM_NET_READ = 1'b0;
    RX_VALID = 1'b0;
    tick();

    // Empty read with a packet arriving in the same cycle
    MEM_NET_READ = 1'b1;
    RX_VALID = 1'b1;
    RX_DATA  = 32'hDEAD;
    tick();
    RX_VALID = 1'b0;
    tick();
    MEM_NET_READ = 1'b0;
    tick();

    // Concurrent: write into a full TX together with a read from a non-empty RX
    TX_READY = 1'b0;
    for (int i = 0; i < 4; i++) do_write(32'h200 + i, 32'hB0 + i);
    rx_send(32'h300);
    rx_send(32'h301);
    MEM_NET_WRITE = 1'b1;
    MEM_ALU_OUT   = 32'h55;
    MEM_REG_DATA2 = 32'h66;
    MEM_NET_READ  = 1'b1;
    tick();
    MEM_NET_READ = 1'b0;
    tick();
    TX_READY = 1'b1;
    n = 0;
    do begin
      @(negedge CLK);
      st = NET_STALL;
      tick();
      n++;
    end while (st && n < 20);
    MEM_NET_WRITE = 1'b0;
    check("concurrent_write", 32'(st), 32'h0);
    MEM_NET_READ = 1'b1;
    tick();
    MEM_NET_READ = 1'b0;
    repeat (6) tick();

    // Random traffic, including a mid-run reset
    for (int i = 0; i < 200; i++) begin
      RESET         = (i == 120) ? 1'b0 : 1'b1;
      MEM_NET_WRITE = 1'($urandom_range(0, 1));
      MEM_NET_READ  = 1'($urandom_range(0, 1));
      MEM_ALU_OUT   = $urandom();
      MEM_REG_DATA2 = $urandom();
      RX_VALID      = 1'($urandom_range(0, 1));
      RX_DATA       = $urandom();
      TX_READY      = 1'($urandom_range(0, 1));
      tick();
    end
    RESET = 1'b1;
    idle_inputs();
    TX_READY = 1'b1;
    MEM_NET_READ = 1'b1;
    repeat (RXD + 1) tick();
    idle_inputs();
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
